dmem_responder: RTL and testbench

DMEM_RESPONDER -- requirements
Module: dmem_responder

---
 rtl/dmem_if.sv | 22 ++
 rtl/dmem_responder.sv | 115 +++++++++++
 tb/tb_dmem_responder.sv | 146 ++++++++++++++
 3 files changed

// File: rtl/dmem_if.sv
// dmem_if: load/store request and response channel between a core and the data memory responder.
interface dmem_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [63:0] rsp_rdata;
  logic        rsp_err;
  modport master (
    output req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );
  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, req_size, req_unsigned, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/dmem_responder.sv
// dmem_responder: single-outstanding 64-bit data memory with fixed response latency.
// Define DMEM_MISALIGN_CHECK_EN to flag misaligned accesses instead of aligning them down.
module dmem_responder #(
  parameter int DEPTH   = 512,
  parameter int LATENCY = 2
) (
  input logic   clk,
  input logic   rst,
  dmem_if.slave bus
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [3:0] LAST = 4'(LATENCY > 0 ? LATENCY - 1 : 0);
  typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;
  state_t        r_state;
  logic [3:0]    r_cnt;
  logic          r_we;
  logic          r_uns;
  logic [1:0]    r_size;
  logic [AW+2:0] r_addr;
  logic [63:0]   r_wdata;
  logic          r_req_ready;
  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic [63:0]   r_rsp_rdata;
  logic [63:0]   r_mem [DEPTH];
  logic          w_idle;
  logic          w_accept;
  logic          w_commit;
  logic          w_we;
  logic          w_uns;
  logic [1:0]    w_size;
  logic [AW+2:0] w_addr;
  logic [63:0]   w_wdata;
  logic [AW-1:0] w_idx;
  logic [2:0]    w_off;
  logic [7:0]    w_mask;
  logic [7:0]    w_be;
  logic [63:0]   w_wshift;
  logic [63:0]   w_raw;
  logic [63:0]   w_ld;
  logic [63:0]   w_rdata;
  logic          w_err;
  logic          w_unused;
  assign w_unused = ^bus.req_addr[63:AW+3];
  assign w_idle   = r_state == IDLE;
  assign w_accept = w_idle && bus.req_valid;
  assign w_commit = (w_accept && LATENCY == 0) || (r_state == WAIT && r_cnt == LAST);
  // With zero latency the access completes on the accept edge, so use the live request.
  assign w_we    = w_idle ? bus.req_we : r_we;
  assign w_uns   = w_idle ? bus.req_unsigned : r_uns;
  assign w_size  = w_idle ? bus.req_size : r_size;
  assign w_addr  = w_idle ? bus.req_addr[AW+2:0] : r_addr;
  assign w_wdata = w_idle ? bus.req_wdata : r_wdata;
  assign w_idx   = w_addr[AW+2:3];
  assign w_off   = w_addr[2:0] & (w_size == 2'd3 ? 3'b000 : w_size == 2'd2 ? 3'b100 :
                                  w_size == 2'd1 ? 3'b110 : 3'b111);
  assign w_mask  = w_size == 2'd3 ? 8'hff : w_size == 2'd2 ? 8'h0f : w_size == 2'd1 ? 8'h03 : 8'h01;
  assign w_be     = w_mask << w_off;
  assign w_wshift = w_wdata << {w_off, 3'b000};
  assign w_raw    = r_mem[w_idx] >> {w_off, 3'b000};
  assign w_ld = w_size == 2'd3 ? w_raw :
                w_size == 2'd2 ? {{32{~w_uns & w_raw[31]}}, w_raw[31:0]} :
                w_size == 2'd1 ? {{48{~w_uns & w_raw[15]}}, w_raw[15:0]} :
                                 {{56{~w_uns & w_raw[7]}}, w_raw[7:0]};
`ifdef DMEM_MISALIGN_CHECK_EN
  assign w_err = w_size == 2'd3 ? |w_addr[2:0] : w_size == 2'd2 ? |w_addr[1:0] :
                 w_size == 2'd1 ? w_addr[0] : 1'b0;
`else
  assign w_err = 1'b0;
`endif
  assign w_rdata = (w_we || w_err) ? 64'd0 : w_ld;
  // Storage is never reset; a store held off by reset is simply dropped.
  always_ff @(posedge clk) begin
    if (!rst && w_commit && w_we && !w_err)
      for (int i = 0; i < 8; i++)
        if (w_be[i]) r_mem[w_idx][i*8 +: 8] <= w_wshift[i*8 +: 8];
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state     <= IDLE;
      r_cnt       <= 4'd0;
      r_req_ready <= 1'b1;
      r_rsp_valid <= 1'b0;
      r_rsp_rdata <= 64'd0;
      r_rsp_err   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_we        <= bus.req_we;
        r_uns       <= bus.req_unsigned;
        r_size      <= bus.req_size;
        r_addr      <= bus.req_addr[AW+2:0];
        r_wdata     <= bus.req_wdata;
        r_cnt       <= 4'd0;
        r_req_ready <= 1'b0;
        r_state     <= WAIT;
      end
      if (r_state == WAIT) r_cnt <= r_cnt + 4'd1;
      if (w_commit) begin
        r_state     <= RESP;
        r_rsp_valid <= 1'b1;
        r_rsp_rdata <= w_rdata;
        r_rsp_err   <= w_err;
      end
      if (r_state == RESP && bus.rsp_ready) begin
        r_state     <= IDLE;
        r_rsp_valid <= 1'b0;
        r_req_ready <= 1'b1;
      end
    end
  end
  assign bus.req_ready = r_req_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_rdata = r_rsp_rdata;
  assign bus.rsp_err   = r_rsp_err;
endmodule

// File: tb/tb_dmem_responder.sv
// tb_dmem_responder: directed vector checks of dmem_responder at LATENCY 2 and LATENCY 0.
module tb_dmem_responder;
`ifdef DMEM_MISALIGN_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  typedef struct {
    logic        we;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [1:0]  size;
    logic        uns;
    logic [63:0] rdata;
    logic        err;
  } vec_t;
  logic clk = 1'b0;
  logic rst;
  int   n_cmp = 0;
  int   n_fail = 0;
  vec_t tv [19];
  always #5 clk = ~clk;
  dmem_if m();
  dmem_if z();
  dmem_responder #(.DEPTH(512), .LATENCY(2)) u_dut  (.clk(clk), .rst(rst), .bus(m));
  dmem_responder #(.DEPTH(512), .LATENCY(0)) u_dut0 (.clk(clk), .rst(rst), .bus(z));
  function automatic vec_t mk(logic we, logic [63:0] addr, logic [63:0] wdata, logic [1:0] size,
                              logic uns, logic [63:0] rdata, logic err);
    vec_t v;
    v.we = we; v.addr = addr; v.wdata = wdata; v.size = size; v.uns = uns; v.rdata = rdata; v.err = err;
    return v;
  endfunction
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask
  task automatic run(input vec_t v, input string name, input bit rel);
    int n;
    @(negedge clk);
    m.req_valid = 1'b1; m.req_we = v.we; m.req_addr = v.addr; m.req_wdata = v.wdata;
    m.req_size = v.size; m.req_unsigned = v.uns; m.rsp_ready = 1'b0;
    chk({name, " req_ready"}, 64'(m.req_ready), 64'd1);
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    n = 1;
    while (!m.rsp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk({name, " latency"}, 64'(n), 64'd3);
    chk({name, " rdata"}, m.rsp_rdata, v.rdata);
    chk({name, " err"}, 64'(m.rsp_err), 64'(v.err));
    if (rel) begin
      m.rsp_ready = 1'b1;
      @(negedge clk);
      m.rsp_ready = 1'b0;
    end
  endtask
  initial begin
    rst = 1'b1;
    m.req_valid = 0; m.req_we = 0; m.req_addr = 0; m.req_wdata = 0; m.req_size = 0; m.req_unsigned = 0; m.rsp_ready = 0;
    z.req_valid = 0; z.req_we = 0; z.req_addr = 0; z.req_wdata = 0; z.req_size = 0; z.req_unsigned = 0; z.rsp_ready = 0;
    tv[0]  = mk(1, 64'h10,   64'h1122334455667788, 3, 0, 64'h0, 0);
    tv[1]  = mk(0, 64'h10,   64'h0, 3, 0, 64'h1122334455667788, 0);
    tv[2]  = mk(1, 64'h13,   64'hAB, 0, 0, 64'h0, 0);
    tv[3]  = mk(0, 64'h10,   64'h0, 3, 0, 64'h11223344AB667788, 0);
    tv[4]  = mk(0, 64'h13,   64'h0, 0, 0, 64'hFFFFFFFFFFFFFFAB, 0);
    tv[5]  = mk(0, 64'h13,   64'h0, 0, 1, 64'h00000000000000AB, 0);
    tv[6]  = mk(0, 64'h14,   64'h0, 1, 0, 64'h0000000000003344, 0);
    tv[7]  = mk(0, 64'h10,   64'h0, 2, 0, 64'hFFFFFFFFAB667788, 0);
    tv[8]  = mk(0, 64'h10,   64'h0, 2, 1, 64'h00000000AB667788, 0);
    tv[9]  = mk(0, 64'h10,   64'h0, 3, 1, 64'h11223344AB667788, 0);
    tv[10] = mk(1, 64'h17,   64'hFFFFFFFFFFFFFF5A, 0, 0, 64'h0, 0);
    tv[11] = mk(0, 64'h10,   64'h0, 3, 0, 64'h5A223344AB667788, 0);
    tv[12] = mk(1, 64'h1000, 64'hCAFEF00D12345678, 3, 0, 64'h0, 0);
    tv[13] = mk(0, 64'h0,    64'h0, 3, 0, 64'hCAFEF00D12345678, 0);
    tv[14] = mk(1, 64'h20,   64'h0102030405060708, 3, 0, 64'h0, 0);
    tv[15] = mk(1, 64'h22,   64'hDEADBEEF, 2, 0, 64'h0, CHK);
    tv[16] = mk(0, 64'h20,   64'h0, 3, 0, CHK ? 64'h0102030405060708 : 64'h01020304DEADBEEF, 0);
    tv[17] = mk(0, 64'h21,   64'h0, 1, 0, CHK ? 64'h0 : 64'hFFFFFFFFFFFFBEEF, CHK);
    tv[18] = mk(0, 64'h16,   64'h0, 1, 1, 64'h0000000000005A22, 0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    chk("reset req_ready", 64'(m.req_ready), 64'd1);
    chk("reset rsp_valid", 64'(m.rsp_valid), 64'd0);
    chk("reset rsp_rdata", m.rsp_rdata, 64'd0);
    chk("reset rsp_err", 64'(m.rsp_err), 64'd0);
    for (int i = 0; i < 19; i++) run(tv[i], $sformatf("vec%0d", i), 1'b1);
    // response held for five cycles while a competing store is offered
    run(mk(0, 64'h10, 64'h0, 3, 0, 64'h5A223344AB667788, 0), "hold", 1'b0);
    m.req_valid = 1'b1; m.req_we = 1'b1; m.req_addr = 64'h10; m.req_wdata = 64'h0; m.req_size = 2'd3;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("hold rsp_valid", 64'(m.rsp_valid), 64'd1);
      chk("hold rsp_rdata", m.rsp_rdata, 64'h5A223344AB667788);
      chk("hold req_ready", 64'(m.req_ready), 64'd0);
    end
    m.req_valid = 1'b0;
    m.rsp_ready = 1'b1;
    @(negedge clk);
    m.rsp_ready = 1'b0;
    chk("release rsp_valid", 64'(m.rsp_valid), 64'd0);
    chk("release req_ready", 64'(m.req_ready), 64'd1);
    run(mk(0, 64'h10, 64'h0, 3, 0, 64'h5A223344AB667788, 0), "after_hold", 1'b1);
    // reset one cycle after accepting a store must discard it
    @(negedge clk);
    m.req_valid = 1'b1; m.req_we = 1'b1; m.req_addr = 64'h20; m.req_wdata = 64'hFF; m.req_size = 2'd0;
    @(posedge clk);
    @(negedge clk);
    m.req_valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_wait rsp_valid", 64'(m.rsp_valid), 64'd0);
    chk("rst_wait req_ready", 64'(m.req_ready), 64'd1);
    run(mk(0, 64'h20, 64'h0, 3, 0, tv[16].rdata, 0), "rst_wait load", 1'b1);
    // zero-latency instance
    @(negedge clk);
    z.req_valid = 1'b1; z.req_we = 1'b1; z.req_addr = 64'h8; z.req_wdata = 64'h55AA55AA00FF00FF; z.req_size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    z.req_valid = 1'b0;
    chk("lat0 store rsp_valid", 64'(z.rsp_valid), 64'd1);
    chk("lat0 store req_ready", 64'(z.req_ready), 64'd0);
    z.rsp_ready = 1'b1;
    @(negedge clk);
    z.rsp_ready = 1'b0;
    chk("lat0 idle req_ready", 64'(z.req_ready), 64'd1);
    z.req_valid = 1'b1; z.req_we = 1'b0; z.req_addr = 64'h1008; z.req_size = 2'd3;
    @(posedge clk);
    @(negedge clk);
    z.req_valid = 1'b0;
    chk("lat0 load rsp_valid", 64'(z.rsp_valid), 64'd1);
    chk("lat0 load rdata", z.rsp_rdata, 64'h55AA55AA00FF00FF);
    z.rsp_ready = 1'b1;
    @(negedge clk);
    z.rsp_ready = 1'b0;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
